mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the instruction-fetch read port and the
//  data-memory read/write port. Used where instruction and data memory share one physical RAM.
//  One transaction is outstanding at a time; data requests have priority, with a starvation guard
//  that lets fetch through. Fetch and MEM stages stall on (req & ~ack) and wait for rvalid.
// PARAMETERS
//  ADDRESS_SIZE  32  address width (matches `ADDRESS_SIZE)
//  DATA_SIZE     32  data width (matches `DATA_SIZE)
//  MEM_LATENCY   2   cycles from a read issue (mem_en=1, mem_we=0) to valid mem_rdata; legal >=1
//  STARVE_LIMIT  4   consecutive data grants that fetch may lose before fetch gets priority; >=1
// PORTS
//  clock      in   1             system clock, rising edge
//  reset      in   1             asynchronous, active-high reset
//  if_req     in   1             fetch read request; held with if_addr until if_ack
//  if_addr    in   ADDRESS_SIZE  fetch read address
//  if_ack     out  1             fetch request accepted this cycle
//  if_rvalid  out  1             if_rdata valid (1 cycle)
//  if_rdata   out  DATA_SIZE     fetch read data
//  dm_req     in   1             data request; held with dm_we/dm_addr/dm_wdata until dm_ack
//  dm_we      in   1             1=write, 0=read
//  dm_addr    in   ADDRESS_SIZE  data address
//  dm_wdata   in   DATA_SIZE     write data
//  dm_ack     out  1             data request accepted; a write completes on this cycle
//  dm_rvalid  out  1             dm_rdata valid (1 cycle; reads only)
//  dm_rdata   out  DATA_SIZE     data read data
//  mem_en     out  1             memory access strobe
//  mem_we     out  1             memory write enable (qualified by mem_en)
//  mem_addr   out  ADDRESS_SIZE  memory address
//  mem_wdata  out  DATA_SIZE     memory write data
//  mem_rdata  in   DATA_SIZE     memory read data, valid MEM_LATENCY cycles after read issue
// BEHAVIOUR
//  - Reset: state=IDLE, lat_cnt=0, starve_cnt=0, owner=none. Every output is 0 while reset is high.
//    Reset during an outstanding read drops it: no rvalid is produced for it.
//  - FSM IDLE: no read outstanding. If any req is high, issue this cycle, combinationally:
//    mem_en=1; mem_addr/mem_we/mem_wdata taken from the winner; winner's ack=1. The other ack=0.
//    Read issued -> WAIT, lat_cnt=MEM_LATENCY-1, owner=winner. Write -> stays IDLE (back-to-back OK).
//  - FSM WAIT: no issue while lat_cnt!=0; decrement each cycle. Cycle lat_cnt==0 is issue cycle
//    T+MEM_LATENCY: owner's rvalid=1, rdata=mem_rdata (pass-through). In that same cycle the FSM
//    acts as IDLE: it may issue a new request (same-cycle return+issue) or go to IDLE.
//  - MEM_LATENCY=1: WAIT lasts exactly one cycle; read-to-read throughput is 1 per cycle.
//  - Arbitration: dm wins by default. If if_req was high and lost to dm on STARVE_LIMIT
//    consecutive grants (starve_cnt==STARVE_LIMIT), fetch wins the next arbitration.
//    starve_cnt: +1 on each dm grant while if_req=1 (saturates at STARVE_LIMIT); cleared on an
//    if grant or on any cycle with if_req=0.
//  - Inactive outputs: mem_en=0 -> mem_we/mem_addr/mem_wdata=0. mem_wdata=0 on reads.
//    rdata=0 when its rvalid=0.
//  - A requester with req=1 and ack=0 holds its request stable. Dropping req before ack is legal
//    (withdraw); nothing is issued for it.
//  - A requester may raise a new req in the cycle of its own rvalid. It is arbitrated that cycle.
// TESTING
//  1. Reset: reset=1 with if_req=dm_req=1 -> all outputs 0. Reset=0 -> issue on the first edge.
//  2. Fetch read, MEM_LATENCY=2: if_req, if_addr=0x40 at T -> if_ack@T, mem_en/addr=0x40@T;
//     mem_rdata=0xDEADBEEF@T+2 -> if_rvalid=1 and if_rdata=0xDEADBEEF@T+2 only.
//  3. Simultaneous: if_req+dm_req(read 0x100)@T -> dm_ack@T, if_ack=0; dm_rvalid@T+2,
//     if_ack@T+2 (same cycle), if_rvalid@T+4.
//  4. Write burst: dm writes 0x10,0x14,0x18 on consecutive cycles -> 3 acks in 3 cycles,
//     mem_we=1 each cycle, no rvalid.
//  5. Starvation, STARVE_LIMIT=4: if_req held, dm_req held (reads) -> 4 dm grants, 5th grant to
//     fetch, then dm again; starve_cnt is 0 after the fetch grant.
//  6. Reset mid-read: read issued @T, reset pulsed @T+1 -> no rvalid @T+2; clean issue after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-port synchronous RAM shared by the instruction
// fetch read port and the data read/write port. One read is outstanding at a
// time. Data requests win by default, and a starvation guard lets fetch through.
//
// state  | meaning
// -------+-------------------------------------------------------------------
// S_IDLE | no read outstanding; arbitrate and issue combinationally
// S_WAIT | read outstanding; r_lat_cnt==0 marks the return cycle, which also
//        | arbitrates like S_IDLE (same-cycle return + issue)
module mem_port_arbiter #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_if_req,
  input  logic [ADDRESS_SIZE-1:0] i_if_addr,
  output logic                    o_if_ack,
  output logic                    o_if_rvalid,
  output logic [DATA_SIZE-1:0]    o_if_rdata,
  input  logic                    i_dm_req,
  input  logic                    i_dm_we,
  input  logic [ADDRESS_SIZE-1:0] i_dm_addr,
  input  logic [DATA_SIZE-1:0]    i_dm_wdata,
  output logic                    o_dm_ack,
  output logic                    o_dm_rvalid,
  output logic [DATA_SIZE-1:0]    o_dm_rdata,
  output logic                    o_mem_en,
  output logic                    o_mem_we,
  output logic [ADDRESS_SIZE-1:0] o_mem_addr,
  output logic [DATA_SIZE-1:0]    o_mem_wdata,
  input  logic [DATA_SIZE-1:0]    i_mem_rdata
);

  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        r_state, w_state_nxt;
  logic [LW-1:0] r_lat_cnt, w_lat_nxt;
  logic [SW-1:0] r_starve_cnt, w_starve_nxt;
  logic          r_owner_dm, w_owner_nxt;
  logic          w_returning;
  logic          w_if_grant;
  logic          w_dm_grant;

  // State, latency counter, starvation counter and read owner registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_owner_dm   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lat_cnt    <= w_lat_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_owner_dm   <= w_owner_nxt;
    end
  end

  // Arbitration, memory strobes, read return and next-state logic.
  // Everything is forced to 0 while reset is high, since the issue path is
  // combinational from the request inputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_lat_nxt    = r_lat_cnt;
    w_starve_nxt = r_starve_cnt;
    w_owner_nxt  = r_owner_dm;
    w_returning  = 1'b0;
    w_if_grant   = 1'b0;
    w_dm_grant   = 1'b0;
    o_if_ack     = 1'b0;
    o_if_rvalid  = 1'b0;
    o_if_rdata   = '0;
    o_dm_ack     = 1'b0;
    o_dm_rvalid  = 1'b0;
    o_dm_rdata   = '0;
    o_mem_en     = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;

    if (!i_reset) begin
      w_returning = (r_state == S_WAIT) && (r_lat_cnt == '0);

      if (w_returning) begin
        if (r_owner_dm) begin
          o_dm_rvalid = 1'b1;
          o_dm_rdata  = i_mem_rdata;
        end else begin
          o_if_rvalid = 1'b1;
          o_if_rdata  = i_mem_rdata;
        end
      end

      if ((r_state == S_WAIT) && (r_lat_cnt != '0)) begin
        w_lat_nxt = r_lat_cnt - 1'b1;
      end else begin
        w_state_nxt = S_IDLE;
        w_if_grant  = i_if_req && (!i_dm_req || (r_starve_cnt == STARVE_MAX));
        w_dm_grant  = i_dm_req && !w_if_grant;

        if (w_if_grant) begin
          o_if_ack    = 1'b1;
          o_mem_en    = 1'b1;
          o_mem_addr  = i_if_addr;
          w_state_nxt = S_WAIT;
          w_lat_nxt   = LAT_INIT;
          w_owner_nxt = 1'b0;
        end else if (w_dm_grant) begin
          o_dm_ack    = 1'b1;
          o_mem_en    = 1'b1;
          o_mem_we    = i_dm_we;
          o_mem_addr  = i_dm_addr;
          o_mem_wdata = i_dm_we ? i_dm_wdata : '0;
          // writes complete on the ack cycle, so only reads occupy the port
          if (!i_dm_we) begin
            w_state_nxt = S_WAIT;
            w_lat_nxt   = LAT_INIT;
            w_owner_nxt = 1'b1;
          end
        end
      end

      if (!i_if_req || w_if_grant) begin
        w_starve_nxt = '0;
      end else if (w_dm_grant && (r_starve_cnt != STARVE_MAX)) begin
        w_starve_nxt = r_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, two hand-written
// multi-cycle sequences (starvation, reset during a read) and a random phase,
// all cross-checked every cycle against a timestamp-based reference model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int SL  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic          if_ack, if_rvalid, dm_ack, dm_rvalid, mem_en, mem_we;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_ack(dm_ack), .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  // memory behaviour: contents plus pending read returns keyed by due cycle
  typedef struct { int due; logic [31:0] data; } rd_t;
  rd_t rq[$];
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // reference model: absolute return cycle of the outstanding read, its owner,
  // and count of consecutive fetch losses
  int m_ret = -1;
  bit m_own_dm = 1'b0;
  int m_starve = 0;
  bit m_if_g = 1'b0, m_dm_g = 1'b0;

  // sampled DUT outputs: ctl = {if_ack, dm_ack, if_rvalid, dm_rvalid, mem_en, mem_we}
  logic [5:0]  s_ctl;
  logic [31:0] s_maddr, s_mwdata, s_ir, s_dr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // one clock cycle: drive at negedge, sample/check 1ns later, update at posedge
  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    logic [31:0] rd, e_addr, e_wd, e_ir, e_dr;
    logic [5:0]  e_ctl;
    bit ret, free;
    rst = r; if_req = ir; if_addr = ia;
    dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
    if (rq.size() > 0 && rq[0].due == cyc) rd = rq.pop_front().data;
    else rd = $urandom;
    mem_rdata = rd;
    #1;
    s_ctl = {if_ack, dm_ack, if_rvalid, dm_rvalid, mem_en, mem_we};
    s_maddr = mem_addr; s_mwdata = mem_wdata; s_ir = if_rdata; s_dr = dm_rdata;

    m_if_g = 1'b0; m_dm_g = 1'b0;
    e_ctl = '0; e_addr = '0; e_wd = '0; e_ir = '0; e_dr = '0;
    if (!r) begin
      ret  = (m_ret == cyc);
      free = (m_ret < 0) || ret;
      if (ret) begin
        if (m_own_dm) begin e_ctl[2] = 1'b1; e_dr = rd; end
        else begin e_ctl[3] = 1'b1; e_ir = rd; end
      end
      if (free) begin
        if (ir && (!dr || m_starve >= SL)) m_if_g = 1'b1;
        else if (dr) m_dm_g = 1'b1;
      end
      if (m_if_g) begin e_ctl[5] = 1'b1; e_ctl[1] = 1'b1; e_addr = ia; end
      if (m_dm_g) begin
        e_ctl[4] = 1'b1; e_ctl[1] = 1'b1; e_ctl[0] = dw; e_addr = da;
        e_wd = dw ? dd : 32'h0;
      end
    end
    chk("ctl", 32'(s_ctl), 32'(e_ctl));
    chk("mem_addr", s_maddr, e_addr);
    chk("mem_wdata", s_mwdata, e_wd);
    chk("if_rdata", s_ir, e_ir);
    chk("dm_rdata", s_dr, e_dr);

    @(posedge clk);
    if (s_ctl[1]) begin
      if (s_ctl[0]) mem[s_maddr] = s_mwdata;
      else rq.push_back('{due: cyc + LAT, data: mem_rd(s_maddr)});
    end
    if (r) begin
      m_ret = -1; m_starve = 0;
    end else begin
      if (m_if_g || (m_dm_g && !dw)) begin m_ret = cyc + LAT; m_own_dm = m_dm_g; end
      else if (m_ret == cyc) m_ret = -1;
      if (!ir || m_if_g) m_starve = 0;
      else if (m_dm_g && m_starve < SL) m_starve++;
    end
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    logic r, ir; logic [31:0] ia;
    logic dr, dw; logic [31:0] da, dd;
    logic [5:0] ctl; logic [31:0] maddr, rdata;
  } vec_t;

  function automatic vec_t mk(logic r, logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [31:0] dd, logic [5:0] ctl,
                              logic [31:0] maddr, logic [31:0] rdata);
    vec_t v;
    v.r = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ctl = ctl; v.maddr = maddr; v.rdata = rdata;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   g[$];
    int   pat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic p_ir = 1'b0, p_dr = 1'b0, p_dw = 1'b0, r;
    logic [31:0] p_ia = '0, p_da = '0, p_dd = '0;

    mem[32'h40]  = 32'hDEAD_BEEF;
    mem[32'h100] = 32'h1111_2222;

    //            rst ir ia     dr dw da      dd     ctl        maddr   rdata
    tbl.push_back(mk(1, 1, 32'h40, 1, 0, 32'h100, 0,     6'b000000, 32'h0,   32'h0));
    tbl.push_back(mk(0, 1, 32'h40, 1, 0, 32'h100, 0,     6'b010010, 32'h100, 32'h0));
    tbl.push_back(mk(0, 1, 32'h40, 0, 0, 32'h0,   0,     6'b000000, 32'h0,   32'h0));
    tbl.push_back(mk(0, 1, 32'h40, 0, 0, 32'h0,   0,     6'b100110, 32'h40,  32'h1111_2222));
    tbl.push_back(mk(0, 0, 32'h0,  0, 0, 32'h0,   0,     6'b000000, 32'h0,   32'h0));
    tbl.push_back(mk(0, 0, 32'h0,  0, 0, 32'h0,   0,     6'b001000, 32'h0,   32'hDEAD_BEEF));
    tbl.push_back(mk(0, 0, 32'h0,  0, 0, 32'h0,   0,     6'b000000, 32'h0,   32'h0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 1, 32'h10,  32'hA0, 6'b010011, 32'h10, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 1, 32'h14,  32'hA1, 6'b010011, 32'h14, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 1, 32'h18,  32'hA2, 6'b010011, 32'h18, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,  0, 0, 32'h0,   0,     6'b000000, 32'h0,   32'h0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 32'h14,  0,     6'b010010, 32'h14,  32'h0));
    tbl.push_back(mk(0, 0, 32'h0,  0, 0, 32'h0,   0,     6'b000000, 32'h0,   32'h0));
    tbl.push_back(mk(0, 0, 32'h0,  0, 0, 32'h0,   0,     6'b000100, 32'h0,   32'hA1));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      chk($sformatf("tbl%0d_ctl", i), 32'(s_ctl), 32'(tbl[i].ctl));
      chk($sformatf("tbl%0d_addr", i), s_maddr, tbl[i].maddr);
      chk($sformatf("tbl%0d_rdata", i), s_ir | s_dr, tbl[i].rdata);
    end

    // starvation: both requesters held, data reads; fetch gets every 5th grant
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 32'h200, 1, 0, 32'h300, 0);
      if (s_ctl[5]) g.push_back(0);
      else if (s_ctl[4]) g.push_back(1);
    end
    chk("starve_ngrants", 32'(g.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve_grant%0d", i), (i < g.size()) ? 32'(g[i]) : 32'd9, 32'(pat[i]));
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // reset in the middle of an outstanding read drops its return
    step(0, 0, 0, 1, 0, 32'h14, 0);
    chk("rstmid_ack", 32'(s_ctl), 32'(6'b010010));
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rstmid_inreset", 32'(s_ctl), 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rstmid_norvalid", 32'(s_ctl), 32'h0);
    step(0, 1, 32'h40, 0, 0, 0, 0);
    chk("rstmid_reissue", 32'(s_ctl), 32'(6'b100010));
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rstmid_rvalid", 32'(s_ctl), 32'(6'b001000));
    chk("rstmid_rdata", s_ir, 32'hDEAD_BEEF);

    // random traffic obeying the hold-until-ack protocol
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      if (!(p_ir && !m_if_g) || $urandom_range(0, 19) == 0) begin
        p_ir = ($urandom_range(0, 2) != 0);
        p_ia = 32'($urandom_range(0, 15)) << 2;
      end
      if (!(p_dr && !m_dm_g) || $urandom_range(0, 19) == 0) begin
        p_dr = ($urandom_range(0, 2) != 0);
        p_dw = ($urandom_range(0, 1) != 0);
        p_da = 32'($urandom_range(0, 15)) << 2;
        p_dd = $urandom;
      end
      step(r, p_ir, p_ia, p_dr, p_dw, p_da, p_dd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
